// File: rtl/spm_mem_responder_pkg.sv
// Shared types and defaults for the RISC-SPM memory responder.
package spm_mem_responder_pkg;
  localparam int WORD_SIZE = 8;
  localparam int ADDR_SIZE = 8;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_IDLE = 2'd1,
    S_WAIT = 2'd2,
    S_ACK  = 2'd3
  } state_t;
endpackage

// File: rtl/spm_mem_responder_if.sv
// CPU access handshake and boot-loader byte stream between requester and responder.
interface spm_mem_responder_if
  import spm_mem_responder_pkg::*;
#(
  parameter int WORD_W = WORD_SIZE,
  parameter int ADDR_W = ADDR_SIZE
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic [WORD_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              ld_valid;
  logic [WORD_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_done;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ld_valid, ld_data, ld_last,
    input  cpu_rdata, cpu_ack, ld_ready, ld_done
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ld_valid, ld_data, ld_last,
    output cpu_rdata, cpu_ack, ld_ready, ld_done
  );
endinterface

// File: rtl/spm_mem_responder_mem_array.sv
// Single-port program/data RAM: synchronous write, registered read, no reset.
module spm_mem_responder_mem_array #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/spm_mem_responder.sv
// Memory-side responder: boot loader fill, then req/ack accesses with programmable wait states.
// state  | meaning
// S_LOAD | accepting boot-loader bytes into mem[ptr]
// S_IDLE | waiting for cpu_req, latches the request
// S_WAIT | counting wait states on the latched request
// S_ACK  | one-cycle ack; RAM write/read happened on the entering edge
module spm_mem_responder
  import spm_mem_responder_pkg::*;
#(
  parameter int word_size   = WORD_SIZE,
  parameter int addr_size   = ADDR_SIZE,
  parameter int WAIT_CYCLES = 2,
  parameter int BOOT_LOAD   = 1
) (
  input logic                 clk,
  input logic                 rst,
  spm_mem_responder_if.slave  bus
);
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [addr_size-1:0]   ptr_q, ptr_d;
  logic [addr_size-1:0]   addr_l_q, addr_l_d;
  logic                   we_l_q, we_l_d;
  logic [word_size-1:0]   wdata_l_q, wdata_l_d;
  logic [word_size-1:0]   rdata_q, rdata_d;
  logic                   ld_ready_q, ld_ready_d;
  logic                   ld_done_q, ld_done_d;

  logic                   mem_we;
  logic [addr_size-1:0]   mem_addr;
  logic [word_size-1:0]   mem_wdata;
  logic [word_size-1:0]   mem_rdata;

  spm_mem_responder_mem_array #(.WORD_W(word_size), .ADDR_W(addr_size)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= (BOOT_LOAD != 0) ? S_LOAD : S_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      addr_l_q   <= '0;
      we_l_q     <= 1'b0;
      wdata_l_q  <= '0;
      rdata_q    <= '0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= (BOOT_LOAD == 0);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      addr_l_q   <= addr_l_d;
      we_l_q     <= we_l_d;
      wdata_l_q  <= wdata_l_d;
      rdata_q    <= rdata_d;
      ld_ready_q <= ld_ready_d;
      ld_done_q  <= ld_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    addr_l_d  = addr_l_q;
    we_l_d    = we_l_q;
    wdata_l_d = wdata_l_q;
    rdata_d   = rdata_q;
    ld_done_d = ld_done_q;
    mem_we    = 1'b0;
    mem_addr  = addr_l_q;
    mem_wdata = wdata_l_q;
    case (state_q)
      S_LOAD: begin
        mem_addr  = ptr_q;
        mem_wdata = bus.ld_data;
        if (bus.ld_valid && ld_ready_q) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + addr_size'(1);
          // the top address ends the load so the pointer never wraps onto address 0
          if (bus.ld_last || (ptr_q == {addr_size{1'b1}})) begin
            state_d   = S_IDLE;
            ld_done_d = 1'b1;
          end
        end
      end
      S_IDLE: begin
        if (bus.cpu_req) begin
          addr_l_d  = bus.cpu_addr;
          we_l_d    = bus.cpu_we;
          wdata_l_d = bus.cpu_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d   = S_ACK;
            mem_we    = bus.cpu_we;
            mem_addr  = bus.cpu_addr;
            mem_wdata = bus.cpu_wdata;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_ACK;
          mem_we  = we_l_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        if (!we_l_q) rdata_d = mem_rdata;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ld_ready_d = (state_d == S_LOAD);

  // during a read ack the RAM output is live; otherwise the last read value is held
  assign bus.cpu_rdata = (state_q == S_ACK && !we_l_q) ? mem_rdata : rdata_q;
  assign bus.cpu_ack   = (state_q == S_ACK);
  assign bus.ld_ready  = ld_ready_q;
  assign bus.ld_done   = ld_done_q;
endmodule

// File: tb/tb_spm_mem_responder.sv
// Scoreboard bench for spm_mem_responder: boot load, timed accesses, reset abort, load wrap.
module tb_spm_mem_responder;
  import spm_mem_responder_pkg::*;

  localparam int W = 2;

  typedef struct {
    bit          is_read;
    logic [7:0]  data;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spm_mem_responder_if bus ();

  spm_mem_responder #(.WAIT_CYCLES(W), .BOOT_LOAD(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          last_ack = -100;
  exp_t        sb[$];
  logic [7:0]  model[256];
  logic [7:0]  img[256];
  logic [7:0]  last_rd;
  int          kq[$];
  int          ack_c[4];
  int          ack_at;
  logic [7:0]  ra;
  bit          rd;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endfunction

  // monitor: every ack must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.cpu_ack) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL spurious_ack: actual ack at cycle %0d required no ack", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_ack_cycle"}, cyc, e.cyc);
        chk({e.name, "_rdata"}, bus.cpu_rdata, e.data);
      end
    end
  end

  // Called at a negedge. A request is sampled at the first edge where the responder is idle,
  // and acknowledged W edges later.
  task automatic issue(input bit we, input logic [7:0] a, input logic [7:0] d, input string nm,
                       output int ackc);
    exp_t e;
    int   samp;
    int   n;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    e.is_read = !we;
    if (we) begin
      model[a] = d;
      e.data   = last_rd;
    end else begin
      e.data  = model[a];
      last_rd = model[a];
    end
    samp   = (cyc + 1 > last_ack + 2) ? cyc + 1 : last_ack + 2;
    e.cyc  = samp + W;
    e.name = nm;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cpu_ack && n < 40);
    if (!bus.cpu_ack) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: actual no ack after %0d cycles required ack", nm, n);
      void'(sb.pop_back());
    end
    last_ack = cyc;
    ackc     = cyc;
  endtask

  task automatic drop_req();
    bus.cpu_req = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; asserts reset immediately so an in-flight access is aborted.
  task automatic do_reset();
    rst          = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    last_rd      = 8'h00;
    last_ack     = -100;
    #1;
    chk("rst_cpu_ack", bus.cpu_ack, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_ld_ready", bus.ld_ready, 0);
    chk("rst_ld_done", bus.ld_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_image(input int n, input bit use_last);
    int k;
    k = 0;
    while (!bus.ld_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("ld_ready_up", bus.ld_ready, 1);
    for (int i = 0; i < n; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = img[i];
      bus.ld_last  = use_last && (i == n - 1);
      model[i]     = img[i];
      @(negedge clk);
      if (i == n - 2) begin
        chk("ld_done_before_last", bus.ld_done, 0);
        chk("ld_ready_before_last", bus.ld_ready, 1);
      end
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    chk("ld_done_after_last", bus.ld_done, 1);
    chk("ld_ready_after_last", bus.ld_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.ld_last   = 1'b0;
    last_rd       = 8'h00;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;

    // boot load of three bytes
    repeat (3) @(negedge clk);
    chk("por_cpu_ack", bus.cpu_ack, 0);
    chk("por_ld_ready", bus.ld_ready, 0);
    chk("por_ld_done", bus.ld_done, 0);
    chk("por_cpu_rdata", bus.cpu_rdata, 0);
    rst = 1'b1;
    img[0] = 8'h51; img[1] = 8'hA0; img[2] = 8'h07;
    load_image(3, 1'b1);

    // timed read, one-cycle ack
    issue(1'b0, 8'h01, 8'h00, "rd_01", ack_at);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", bus.cpu_ack, 0);
    issue(1'b0, 8'h00, 8'h00, "rd_00", ack_at);
    drop_req();
    issue(1'b0, 8'h02, 8'h00, "rd_02", ack_at);
    drop_req();

    // write then read back; rdata holds through the write ack
    issue(1'b1, 8'h80, 8'h3C, "wr_80", ack_at);
    drop_req();
    issue(1'b0, 8'h80, 8'h00, "rd_80", ack_at);
    drop_req();

    // request held high through four reads
    issue(1'b0, 8'h01, 8'h00, "held_rd0", ack_c[0]);
    issue(1'b0, 8'h80, 8'h00, "held_rd1", ack_c[1]);
    issue(1'b0, 8'h02, 8'h00, "held_rd2", ack_c[2]);
    issue(1'b0, 8'h00, 8'h00, "held_rd3", ack_c[3]);
    drop_req();
    for (int i = 1; i < 4; i++) chk("held_spacing", ack_c[i] - ack_c[i-1], W + 2);

    // random mix of writes and reads of known addresses, sometimes back-to-back
    kq.push_back(0); kq.push_back(1); kq.push_back(2); kq.push_back(8'h80);
    for (int i = 0; i < 24; i++) begin
      rd = ($urandom_range(0, 1) == 1);
      if (rd) begin
        ra = 8'(kq[$urandom_range(0, kq.size() - 1)]);
        issue(1'b0, ra, 8'h00, "rnd_rd", ack_at);
      end else begin
        ra = 8'($urandom_range(0, 255));
        issue(1'b1, ra, 8'($urandom), "rnd_wr", ack_at);
        kq.push_back(int'(ra));
      end
      if ($urandom_range(0, 1) == 1) drop_req();
    end
    drop_req();

    // reset during the wait states of a write aborts it
    issue(1'b1, 8'h40, 8'h11, "wr_40_old", ack_at);
    drop_req();
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 8'h40;
    bus.cpu_wdata = 8'hEE;
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // request pending during reload is served only after ld_done
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 8'h40;
    repeat (3) @(negedge clk);
    load_image(3, 1'b1);
    begin
      exp_t e;
      int   n;
      e.is_read = 1'b1;
      e.data    = model[8'h40];
      e.cyc     = cyc + 1 + W;
      e.name    = "rd_40_after_reload";
      last_rd   = model[8'h40];
      sb.push_back(e);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.cpu_ack && n < 40);
      chk("rd_40_after_reload_seen", bus.cpu_ack, 1);
      last_ack = cyc;
    end
    drop_req();

    // full-depth load ends at the top address; later loader bytes are ignored
    do_reset();
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    load_image(256, 1'b0);
    bus.ld_valid = 1'b1;
    bus.ld_data  = ~img[0];
    bus.ld_last  = 1'b1;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    chk("ld_ready_stays_low", bus.ld_ready, 0);
    chk("ld_done_sticky", bus.ld_done, 1);
    issue(1'b0, 8'h00, 8'h00, "wrap_rd_00", ack_at);
    drop_req();
    issue(1'b0, 8'hFF, 8'h00, "wrap_rd_ff", ack_at);
    issue(1'b0, 8'h40, 8'h00, "wrap_rd_40", ack_at);
    drop_req();

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
